// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module   : alu_issue_stage
// Brief    : MIPS ALU issue stage. Decodes, drives the ALU from registers and
//            captures the result in a valid/ready output register.
//            Optional statistics counters: define ALU_ISSUE_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_issue_stage #(
    parameter logic [3:0] ILLEGAL_OP = 4'b1111,
    parameter int         CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs_val,
    input  logic [31:0]      rt_val,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [4:0]       alu_shamt,
    output logic [3:0]       alu_control,
    input  logic [31:0]      alu_result,
    input  logic             alu_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_zero,
    output logic [4:0]       out_rd,
`ifdef ALU_ISSUE_STATS_EN
    output logic [CNT_W-1:0] stat_issued,
    output logic [CNT_W-1:0] stat_illegal,
`endif
    output logic             out_illegal
);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0011;
    localparam logic [3:0] C_XOR = 4'b0100;
    localparam logic [3:0] C_NOT = 4'b0101;
    localparam logic [3:0] C_SLL = 4'b0110;
    localparam logic [3:0] C_SRL = 4'b0111;
    localparam logic [3:0] C_SRA = 4'b1000;
    localparam logic [3:0] C_SLT = 4'b1001;
    localparam logic [3:0] C_SEQ = 4'b1010;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [31:0] w_simm;
    logic [31:0] w_zimm;
    logic [3:0]  w_ctrl;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic [4:0]  w_rd;
    logic        w_illegal;
    logic        w_adv2;
    logic        w_accept;
    logic        w_unused_rs_field;

    logic        r_s1_valid;
    logic [4:0]  r_s1_rd;
    logic        r_s1_illegal;

    assign w_op    = instr[31:26];
    assign w_funct = instr[5:0];
    assign w_simm  = {{16{instr[15]}}, instr[15:0]};
    assign w_zimm  = {16'h0000, instr[15:0]};
    // Operand values arrive already read from the register file.
    assign w_unused_rs_field = ^instr[25:21];

    always_comb begin
        w_ctrl    = ILLEGAL_OP;
        w_a       = '0;
        w_b       = '0;
        w_shamt   = '0;
        w_rd      = '0;
        w_illegal = 1'b1;
        case (w_op)
            6'h00: begin
                w_illegal = 1'b0;
                w_a       = rs_val;
                w_b       = rt_val;
                w_rd      = instr[15:11];
                case (w_funct)
                    6'h24: w_ctrl = C_AND;
                    6'h25: w_ctrl = C_OR;
                    6'h20: w_ctrl = C_ADD;
                    6'h22: w_ctrl = C_SUB;
                    6'h26: w_ctrl = C_XOR;
                    6'h27, 6'h28: w_ctrl = (w_funct == 6'h28) ? C_NOT : ILLEGAL_OP;
                    6'h2A: w_ctrl = C_SLT;
                    6'h29: w_ctrl = C_SEQ;
                    6'h00, 6'h02, 6'h03: begin
                        w_ctrl  = (w_funct == 6'h00) ? C_SLL :
                                  (w_funct == 6'h02) ? C_SRL : C_SRA;
                        w_a     = rt_val;
                        w_shamt = instr[10:6];
                    end
                    default: w_ctrl = ILLEGAL_OP;
                endcase
                if (w_ctrl == ILLEGAL_OP) begin
                    w_illegal = 1'b1;
                    w_a       = '0;
                    w_b       = '0;
                    w_shamt   = '0;
                    w_rd      = '0;
                end
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                w_illegal = 1'b0;
                w_a       = rs_val;
                w_rd      = instr[20:16];
                case (w_op)
                    6'h08:   begin w_ctrl = C_ADD; w_b = w_simm; end
                    6'h0A:   begin w_ctrl = C_SLT; w_b = w_simm; end
                    6'h0C:   begin w_ctrl = C_AND; w_b = w_zimm; end
                    6'h0D:   begin w_ctrl = C_OR;  w_b = w_zimm; end
                    default: begin w_ctrl = C_XOR; w_b = w_zimm; end
                endcase
            end
            6'h04: begin
                w_illegal = 1'b0;
                w_ctrl    = C_SUB;
                w_a       = rs_val;
                w_b       = rt_val;
            end
            default: ;
        endcase
    end

    assign w_adv2   = r_s1_valid & (~out_valid | out_ready);
    assign in_ready = ~r_s1_valid | w_adv2;
    assign w_accept = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_shamt    <= '0;
            alu_control  <= ILLEGAL_OP;
            r_s1_rd      <= '0;
            r_s1_illegal <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            alu_a        <= w_a;
            alu_b        <= w_b;
            alu_shamt    <= w_shamt;
            alu_control  <= w_ctrl;
            r_s1_rd      <= w_rd;
            r_s1_illegal <= w_illegal;
        end else if (w_adv2) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_rd      <= '0;
            out_illegal <= 1'b0;
        end else if (w_adv2) begin
            out_valid   <= 1'b1;
            out_result  <= alu_result;
            out_zero    <= alu_zero;
            out_rd      <= r_s1_rd;
            out_illegal <= r_s1_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else if (out_valid && out_ready) begin
            stat_issued <= stat_issued + 1'b1;
            if (out_illegal) begin
                stat_illegal <= stat_illegal + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module   : tb_alu_issue_stage
// Brief    : Directed self-checking bench for alu_issue_stage with an ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [4:0]  out_rd;
    logic        out_illegal;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] stat_issued;
    logic [15:0] stat_illegal;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .rs_val      (rs_val),
        .rt_val      (rt_val),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_shamt   (alu_shamt),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_rd      (out_rd),
`ifdef ALU_ISSUE_STATS_EN
        .stat_issued (stat_issued),
        .stat_illegal(stat_illegal),
`endif
        .out_illegal (out_illegal)
    );

    // Reference ALU sitting between the stages.
    always_comb begin
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a - alu_b;
            4'b0100: alu_result = alu_a ^ alu_b;
            4'b0101: alu_result = ~alu_a;
            4'b0110: alu_result = alu_a << alu_shamt;
            4'b0111: alu_result = alu_a >> alu_shamt;
            4'b1000: alu_result = $unsigned($signed(alu_a) >>> alu_shamt);
            4'b1001: alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'b1010: alu_result = {31'd0, alu_a == alu_b};
            default: alu_result = 32'd0;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered and left on a negedge; checks the ALU drive one cycle after
    // acceptance and the captured output two cycles after.
    task automatic one_op(input string tag, input logic [31:0] i, input logic [31:0] rs,
                          input logic [31:0] rt, input logic [3:0] e_ctrl,
                          input logic [31:0] e_a, input logic [31:0] e_b,
                          input logic [4:0] e_sh, input logic [31:0] e_res,
                          input logic e_zero, input logic [4:0] e_rd, input logic e_ill);
        instr = i; rs_val = rs; rt_val = rt; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, ".ctrl"},  {28'd0, alu_control}, {28'd0, e_ctrl});
        chk({tag, ".a"},     alu_a, e_a);
        chk({tag, ".b"},     alu_b, e_b);
        chk({tag, ".shamt"}, {27'd0, alu_shamt}, {27'd0, e_sh});
        @(negedge clk);
        chk({tag, ".ovalid"},  {31'd0, out_valid}, 32'd1);
        chk({tag, ".result"},  out_result, e_res);
        chk({tag, ".zero"},    {31'd0, out_zero}, {31'd0, e_zero});
        chk({tag, ".rd"},      {27'd0, out_rd}, {27'd0, e_rd});
        chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e_ill});
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_val = '0; rt_val = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.in_ready",  {31'd0, in_ready}, 32'd1);
        chk("rst.ctrl",      {28'd0, alu_control}, 32'hF);
        chk("rst.alu_a",     alu_a, 32'd0);
        chk("rst.out_result", out_result, 32'd0);
        chk("rst.out_rd",    {27'd0, out_rd}, 32'd0);

        //      tag      instr         rs            rt            ctrl  a             b             sh     result        z     rd     ill
        one_op("add",  32'h00221820, 32'd5,        32'd7,        4'h2, 32'd5,        32'd7,        5'd0,  32'd12,       1'b0, 5'd3,  1'b0);
        one_op("sra",  32'h00022103, 32'd0,        32'h80000000, 4'h8, 32'h80000000, 32'h80000000, 5'd4,  32'hF8000000, 1'b0, 5'd4,  1'b0);
        one_op("addi", 32'h2025FFFF, 32'd1,        32'd0,        4'h2, 32'd1,        32'hFFFFFFFF, 5'd0,  32'd0,        1'b1, 5'd5,  1'b0);
        one_op("andi", 32'h3026FFFF, 32'h12345678, 32'd0,        4'h0, 32'h12345678, 32'h0000FFFF, 5'd0,  32'h00005678, 1'b0, 5'd6,  1'b0);
        one_op("beqT", 32'h10220010, 32'd9,        32'd9,        4'h3, 32'd9,        32'd9,        5'd0,  32'd0,        1'b1, 5'd0,  1'b0);
        one_op("beqN", 32'h10220010, 32'd9,        32'd8,        4'h3, 32'd9,        32'd8,        5'd0,  32'd1,        1'b0, 5'd0,  1'b0);
        one_op("slti", 32'h2827FFFE, 32'hFFFFFFFD, 32'd0,        4'h9, 32'hFFFFFFFD, 32'hFFFFFFFE, 5'd0,  32'd1,        1'b0, 5'd7,  1'b0);
        one_op("ori",  32'h34288001, 32'h000000F0, 32'd0,        4'h1, 32'h000000F0, 32'h00008001, 5'd0,  32'h000080F1, 1'b0, 5'd8,  1'b0);
        one_op("xori", 32'h3829FFFF, 32'h0000F0F0, 32'd0,        4'h4, 32'h0000F0F0, 32'h0000FFFF, 5'd0,  32'h00000F0F, 1'b0, 5'd9,  1'b0);
        one_op("sll",  32'h00025200, 32'd0,        32'd1,        4'h6, 32'd1,        32'd1,        5'd8,  32'h00000100, 1'b0, 5'd10, 1'b0);
        one_op("srl",  32'h00025FC2, 32'd0,        32'h80000000, 4'h7, 32'h80000000, 32'h80000000, 5'd31, 32'd1,        1'b0, 5'd11, 1'b0);
        one_op("slt",  32'h0022602A, 32'hFFFFFFFF, 32'd1,        4'h9, 32'hFFFFFFFF, 32'd1,        5'd0,  32'd1,        1'b0, 5'd12, 1'b0);
        one_op("seq",  32'h00226829, 32'd44,       32'd44,       4'hA, 32'd44,       32'd44,       5'd0,  32'd1,        1'b0, 5'd13, 1'b0);
        one_op("sub",  32'h00227022, 32'd3,        32'd5,        4'h3, 32'd3,        32'd5,        5'd0,  32'hFFFFFFFE, 1'b0, 5'd14, 1'b0);
        one_op("ill3F",32'hFC221820, 32'd5,        32'd7,        4'hF, 32'd0,        32'd0,        5'd0,  32'd0,        1'b1, 5'd0,  1'b1);
        one_op("illfn",32'h0022183F, 32'd5,        32'd7,        4'hF, 32'd0,        32'd0,        5'd0,  32'd0,        1'b1, 5'd0,  1'b1);

        // Back-pressure: A=add 1+2 (rd 1), B=sub 10-4 (rd 2), C=xor F0^0F (rd 3)
        @(negedge clk);
        chk("bp.drained", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00220820; rs_val = 32'd1;  rt_val = 32'd2;
        @(negedge clk);
        instr = 32'h00221022; rs_val = 32'd10; rt_val = 32'd4;
        @(negedge clk);
        chk("bp.outA.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.outA.res",   out_result, 32'd3);
        instr = 32'h00221826; rs_val = 32'hF0; rt_val = 32'h0F;
        repeat (2) begin
            @(negedge clk);
            chk("bp.in_ready",  {31'd0, in_ready}, 32'd0);
            chk("bp.hold.res",  out_result, 32'd3);
            chk("bp.hold.rd",   {27'd0, out_rd}, 32'd1);
            chk("bp.hold.ctrl", {28'd0, alu_control}, 32'h3);
            chk("bp.hold.alu",  alu_result, 32'd6);
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp.outB.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.outB.res",   out_result, 32'd6);
        chk("bp.outB.rd",    {27'd0, out_rd}, 32'd2);
        @(negedge clk);
        chk("bp.outC.valid", {31'd0, out_valid}, 32'd1);
        chk("bp.outC.res",   out_result, 32'hFF);
        chk("bp.outC.rd",    {27'd0, out_rd}, 32'd3);
        @(negedge clk);
        chk("bp.empty", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full
        out_ready = 1'b0; in_valid = 1'b1;
        instr = 32'h00221820; rs_val = 32'd5; rt_val = 32'd7;
        repeat (2) @(negedge clk);
        chk("mid.full.valid", {31'd0, out_valid}, 32'd1);
        chk("mid.full.in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid.in_ready",  {31'd0, in_ready}, 32'd1);
        chk("mid.ctrl",      {28'd0, alu_control}, 32'hF);
        chk("mid.alu_a",     alu_a, 32'd0);
        chk("mid.out_result", out_result, 32'd0);
        chk("mid.out_rd",    {27'd0, out_rd}, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid.no_ghost", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
